// File: rtl/sequence_generator_if.sv
// Serial pattern transmitter bus: request side (start, pattern, len,
// optional repeat_n) and serial side (x, valid, busy, done).
// Ports: master drives the request and observes the serial line;
//        slave is the generator.
// Optional: SEQ_GEN_REPEAT_EN adds the repeat_n field.
interface sequence_generator_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
) ();
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
`ifdef SEQ_GEN_REPEAT_EN
    logic [CNT_W-1:0] repeat_n;
`endif
    logic             x;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output pattern,
        output len,
`ifdef SEQ_GEN_REPEAT_EN
        output repeat_n,
`endif
        input  x,
        input  valid,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  pattern,
        input  len,
`ifdef SEQ_GEN_REPEAT_EN
        input  repeat_n,
`endif
        output x,
        output valid,
        output busy,
        output done
    );
endinterface

// File: rtl/sequence_generator.sv
// Serial bit-pattern transmitter: latches a right-aligned pattern on
// start and shifts it out MSB-of-window first, one bit per clock.
// Ports: clk, reset (sync, active-low), bus (sequence_generator_if.slave):
//   start/pattern/len[/repeat_n] in; x/valid/busy/done out (registered).
// Optional: SEQ_GEN_REPEAT_EN enables repeat_n and the pass counter.
module sequence_generator #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    sequence_generator_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;

    // sh_q holds the remaining window left-aligned; its MSB is on x.
    logic [PAT_W-1:0] sh_q;
    logic [PAT_W-1:0] sh_d;
    // pat_q keeps the left-aligned window for reloading between passes.
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] pat_d;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;
    // top_q = L-1, the counter reload value.
    logic [LEN_W-1:0] top_q;
    logic [LEN_W-1:0] top_d;

    logic             x_q;
    logic             x_d;
    logic             valid_q;
    logic             valid_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;

    logic [LEN_W-1:0] eff_len;
    logic [PAT_W-1:0] aligned;
    logic             last_pass;

`ifdef SEQ_GEN_REPEAT_EN
    // pass_q counts passes remaining, including the current one.
    logic [CNT_W-1:0] pass_q;
    logic [CNT_W-1:0] pass_d;
    logic [CNT_W-1:0] eff_pass;

    assign eff_pass  = (bus.repeat_n != '0) ? bus.repeat_n
                                            : CNT_W'(1);
    assign last_pass = (pass_q <= CNT_W'(1));
`else
    localparam logic [CNT_W-1:0] PASSES = CNT_W'(1);

    assign last_pass = (PASSES == CNT_W'(1));
`endif

    // Out-of-range lengths (0 or wider than the register) send the
    // full pattern.
    always_comb begin
        eff_len = LEN_W'(PAT_W);
        if (bus.len != '0 && bus.len <= LEN_W'(PAT_W)) begin
            eff_len = bus.len;
        end
    end

    // Left-align the active window so the shift always exits the MSB.
    assign aligned = bus.pattern << (LEN_W'(PAT_W) - eff_len);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        top_d   = top_q;
`ifdef SEQ_GEN_REPEAT_EN
        pass_d  = pass_q;
`endif
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SEND;
                    sh_d    = aligned;
                    pat_d   = aligned;
                    top_d   = eff_len - LEN_W'(1);
                    cnt_d   = eff_len - LEN_W'(1);
`ifdef SEQ_GEN_REPEAT_EN
                    pass_d  = eff_pass;
`endif
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SEND: begin
                if (cnt_q != '0) begin
                    sh_d    = sh_q << 1;
                    cnt_d   = cnt_q - LEN_W'(1);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (!last_pass) begin
                    // Back-to-back pass: reload with no gap cycle.
                    sh_d    = pat_q;
                    cnt_d   = top_q;
`ifdef SEQ_GEN_REPEAT_EN
                    pass_d  = pass_q - CNT_W'(1);
`endif
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        x_d = valid_d & sh_d[PAT_W-1];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            pat_q   <= '0;
            cnt_q   <= '0;
            top_q   <= '0;
`ifdef SEQ_GEN_REPEAT_EN
            pass_q  <= '0;
`endif
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            top_q   <= top_d;
`ifdef SEQ_GEN_REPEAT_EN
            pass_q  <= pass_d;
`endif
            x_q     <= x_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.x     = x_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: doc/sequence_generator.md
# sequence_generator

Serial bit-pattern transmitter: it captures a parallel pattern on a start request and drives it out one bit per clock, MSB of the active window first. It is the driving end of the serial `x` line consumed by `sequence_detector`. Benches and higher-level logic use it to feed detector chains without hand-written per-cycle stimulus. A one-cycle `done` pulse marks the end of each transmission.

## Interface
- `PAT_W`, 8: pattern register width, in bits.
- `LEN_W`, 4: width of `len`; must hold the value `PAT_W`.
- `CNT_W`, 4: width of `repeat_n`.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `start` in 1: transmit request; honoured only in IDLE.
- `pattern` in `PAT_W`: bits to send, right-aligned; captured on the accepting edge.
- `len` in `LEN_W`: number of bits to send, from `pattern[len-1]` down to `pattern[0]`.
- `repeat_n` in `CNT_W`: total number of passes; present only with `SEQ_GEN_REPEAT_EN`.
- `x` out 1: serial data, registered.
- `valid` out 1: `x` carries a pattern bit this cycle.
- `busy` out 1: high while in SEND.
- `done` out 1: one-cycle pulse after the final bit.

## Operation
- FSM states: IDLE, SEND, DONE.
- **IDLE**
  - Outputs: `x`=0, `valid`=0, `busy`=0, `done`=0.
  - If `start`=1: latch `pattern` into a shift register, latch the effective length `L` and the pass count `P`, and go to SEND.
- **SEND**
  - Outputs: `x` = current bit, `valid`=1, `busy`=1.
  - Shift left each cycle; a bit counter counts down from `L-1`.
  - When the counter reaches 0 and passes remain: reload the latched pattern, decrement the remaining-pass count, restart at bit `L-1`. There is no gap cycle between passes.
  - When the counter reaches 0 on the last pass: go to DONE.
- **DONE**
  - Outputs: `done`=1, `valid`=0, `x`=0, `busy`=0.
  - Go unconditionally to IDLE on the next edge.
- Length rule: `L` = `len` if 1 ≤ `len` ≤ `PAT_W`; otherwise `L` = `PAT_W`.
- Pass rule: `P` = `repeat_n` if `repeat_n` ≠ 0; otherwise `P` = 1.
- Input capture: `pattern`, `len` and `repeat_n` are sampled only on the accepting edge. Later changes have no effect on the transmission in progress.
- `start` in SEND or DONE is ignored. It is not queued, and no error is flagged.
- Reset (`reset`=0 at any edge, including mid-SEND): next state is IDLE and all outputs go to 0. Shift register, counters and latched inputs clear to 0. Reset wins over `start` at the same edge.

## Timing
- Reset values: `x`=0, `valid`=0, `busy`=0, `done`=0; state IDLE.
- Let E0 be the edge where `start` is accepted.
  - Bit `k` of the stream (k = 0 … `L*P`-1) is on `x` during the cycle after edge E0+k.
  - First bit after E0 is `pattern[L-1]`; start-to-first-bit latency is 1 cycle.
- After edge E0+`L*P`: state DONE, `done`=1 for exactly one cycle.
- After edge E0+`L*P`+1: state IDLE.
- Minimum spacing between accepted starts: `L*P`+2 cycles.
- `valid` and `busy` are high for exactly `L*P` consecutive cycles.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Configuration
- `SEQ_GEN_REPEAT_EN` defined:
  - The `repeat_n` port and the pass counter exist.
  - `P` follows the pass rule.
- `SEQ_GEN_REPEAT_EN` undefined:
  - No `repeat_n` port and no pass counter.
  - `P` is fixed at 1.
  - All other behaviour is identical.

## Test plan
- Reset:
  - Stimulus: hold `reset`=0 for 2 edges with `start`=1.
  - Required: all outputs stay 0, state stays IDLE, no transmission begins.
- Basic send:
  - Stimulus: `pattern`=8'h36, `len`=8, pulse `start`.
  - Required: `x` = 0,0,1,1,0,1,1,0 on 8 consecutive cycles with `valid`=1; then `done`=1 for 1 cycle; then IDLE.
- Short length:
  - Stimulus: `pattern`=8'hF6, `len`=4.
  - Required: `x` = 0,1,1,0; `done` at E0+4.
  - Repeat with `len`=0: required full 8 bits, 1,1,1,1,0,1,1,0.
- Repeat (macro on):
  - Stimulus: `pattern`=8'h06, `len`=4, `repeat_n`=3.
  - Required: 0110 0110 0110 over 12 back-to-back valid cycles; `done` at E0+12.
  - Repeat with `repeat_n`=0: required single pass.
- Ignored start:
  - Stimulus: reassert `start` with `pattern`=8'hFF mid-SEND and again in DONE.
  - Required: the original stream completes unchanged; no second transmission.
- Reset mid-operation:
  - Stimulus: `reset`=0 at E0+3 of an 8-bit send.
  - Required: `x`/`valid`/`busy` are 0 in the next cycle and `done` never pulses.
  - Then a fresh `start` transmits correctly from bit `L-1`.
